// File: rtl/counter_8bit_pkg.sv
// Shared constants for the free-running terminal-count counter.
package counter_8bit_pkg;

  localparam int COUNTER_WIDTH = 8;
  localparam logic [COUNTER_WIDTH-1:0] COUNTER_MAX = {COUNTER_WIDTH{1'b1}};

endpackage : counter_8bit_pkg

// File: rtl/counter_8bit.sv
// Free-running binary up-counter; overflow is high exactly while count is all ones.
module counter_8bit
  import counter_8bit_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = (WIDTH == COUNTER_WIDTH) ? WIDTH'(COUNTER_MAX)
                                                                  : {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             overflow_reg;
  logic             overflow_next;

  // Flag is decoded from the next count so it lands on the same edge as the count.
  always_comb begin
    count_next    = count_reg + ONE;
    overflow_next = (count_next == MAX_VAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule : counter_8bit

// File: tb/tb_counter_8bit.sv
// Self-checking bench for counter_8bit: directed table, corner sequences, random runs.
`timescale 1ns/1ps
module tb_counter_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] count;
  logic       overflow;

  int checks;
  int errors;
  int edges_since_release;

  counter_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         edges;
    logic [7:0] exp_count;
    logic       exp_ovf;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [7:0] exp_c, input logic exp_o);
    checks++;
    if (count !== exp_c || overflow !== exp_o) begin
      errors++;
      $display("FAIL %s: got count=%02h overflow=%b, expected count=%02h overflow=%b",
               name, count, overflow, exp_c, exp_o);
    end
  endtask

  // Reference model: count is just the number of edges since release, mod 256.
  function automatic logic [7:0] model_count();
    return 8'((edges_since_release % 256));
  endfunction

  function automatic logic model_ovf();
    return (edges_since_release % 256) == 255;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      edges_since_release++;
    end
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    edges_since_release = 0;
  endtask

  // Called 1ns after a rising edge: assert reset mid-cycle and verify the immediate clear.
  task automatic async_reset(input string name);
    #1;
    rst = 1'b1;
    #1;
    check(name, 8'h00, 1'b0);
    $display("async reset %s: count=%02h overflow=%b", name, count, overflow);
    release_rst();
  endtask

  vec_t vecs[3];
  int   ovf_hits;
  int   k;

  initial begin
    checks = 0;
    errors = 0;
    edges_since_release = 0;
    rst = 1'b1;

    vecs[0] = '{255, 8'hFF, 1'b1, "edge255"};
    vecs[1] = '{1,   8'h00, 1'b0, "wrap256"};
    vecs[2] = '{10,  8'h0A, 1'b0, "edge266"};

    #100;
    check("reset_hold", 8'h00, 1'b0);
    $display("reset hold: count=%02h overflow=%b", count, overflow);
    release_rst();

    for (int i = 0; i < 3; i++) begin
      step(vecs[i].edges);
      check(vecs[i].name, vecs[i].exp_count, vecs[i].exp_ovf);
      $display("vec %s: +%0d edges count=%02h overflow=%b", vecs[i].name, vecs[i].edges,
               count, overflow);
    end

    // Walk to 8'hFF, then reset mid-cycle while the flag is high.
    step(245);
    check("at_ff", 8'hFF, 1'b1);
    async_reset("rst_at_ff");
    step(3);
    check("restart3", 8'h03, 1'b0);
    $display("restart: count=%02h overflow=%b", count, overflow);

    // Randomised runs with occasional mid-cycle resets, checked against the model.
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(1, 400));
      step(k);
      check($sformatf("rand%0d", i), model_count(), model_ovf());
      $display("rand %0d: +%0d edges count=%02h overflow=%b", i, k, count, overflow);
      if ($urandom_range(0, 3) == 0) async_reset($sformatf("rand_rst%0d", i));
    end

    // 1024 edges from a clean restart: flag must pulse exactly four times at 8'hFF.
    @(posedge clk);
    async_reset("pre_period");
    ovf_hits = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1);
      check($sformatf("period%0d", i), model_count(), model_ovf());
      if (overflow === 1'b1) ovf_hits++;
    end
    checks++;
    if (ovf_hits != 4) begin
      errors++;
      $display("FAIL ovf_hits: got %0d pulses, expected 4", ovf_hits);
    end
    $display("period run: 1024 edges, overflow pulses=%0d", ovf_hits);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_counter_8bit
